// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: shared fetch exception codes, FSM states and queue-entry type
package fetch_prefetch_pkg;
  typedef enum logic [1:0] {EXC_NONE = 2'd0, EXC_MISALIGNED = 2'd1, EXC_OUT_OF_RANGE = 2'd2} except_e;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    except_e     except;
  } entry_t;
endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: instruction output stream (o_valid/i_ready handshake with o_pc, o_instr, o_except)
interface fetch_prefetch_if;
  import fetch_prefetch_pkg::*;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  except_e     o_except;
  modport master (output o_valid, o_pc, o_instr, o_except, input i_ready);
  modport slave (input o_valid, o_pc, o_instr, o_except, output i_ready);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries; ports i_push/i_data, i_pop, i_flush in, o_head/o_count/o_full/o_empty out
module fetch_queue
  import fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  entry_t                 i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output entry_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    o_empty = wr_q == rd_q;
    o_full  = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
    o_count = wr_q - rd_q;
    o_head  = mem[rd_q[PW-1:0]];
    do_push = i_push && (!o_full || i_pop);
    do_pop  = i_pop && !o_empty;
    wr_d    = i_flush ? '0 : wr_q + {{PW{1'b0}}, do_push};
    rd_d    = i_flush ? '0 : rd_q + {{PW{1'b0}}, do_pop};
  end
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_q[PW-1:0]] <= i_data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction prefetcher; ports i_clk, i_rst_n, i_redirect/i_redirect_pc, program-load i_ld_*, output stream bus
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_redirect,
  input  logic [31:0]                  i_redirect_pc,
  input  logic                         i_ld_we,
  input  logic [$clog2(RAM_WORDS)-1:0] i_ld_addr,
  input  logic [31:0]                  i_ld_data,
  fetch_prefetch_if.master             bus
);
  localparam int          AW    = $clog2(RAM_WORDS);
  localparam int          CW    = $clog2(QDEPTH) + 1;
  localparam logic [31:0] LIMIT = 32'(RAM_WORDS * 4);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] rdata_q;
  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d, ipc_q, ipc_d;
  except_e     iexc_q, iexc_d, exc;
  logic        inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic        full, empty, issue, rd_en, push, pop;
  entry_t      head, wdata;
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(push), .i_data(wdata), .i_pop(pop),
    .i_flush(i_redirect), .o_head(head), .o_count(count), .o_full(full), .o_empty(empty)
  );
  // Exceptions ride the same one-cycle in-flight slot as reads so they consume credit identically.
  always_comb begin
    exc        = fpc_q[1:0] != 2'b00 ? EXC_MISALIGNED : fpc_q >= LIMIT ? EXC_OUT_OF_RANGE : EXC_NONE;
    issue      = state_q == RUN && !i_redirect && 32'(count) + 32'(inflight_q) < 32'(QDEPTH);
    rd_en      = issue && exc == EXC_NONE;
    pop        = !empty && bus.i_ready && !i_redirect;
    push       = inflight_q && !i_redirect && (!full || pop);
    wdata      = '{pc: ipc_q, instr: iexc_q == EXC_NONE ? rdata_q : 32'h0, except: iexc_q};
    fpc_d      = i_redirect ? i_redirect_pc : issue ? fpc_q + 32'd4 : fpc_q;
    state_d    = i_redirect ? RUN : issue && exc != EXC_NONE ? HALT : state_q;
    inflight_d = issue;
    ipc_d      = fpc_q;
    iexc_d     = exc;
    bus.o_valid  = !empty;
    bus.o_pc     = empty ? 32'h0 : head.pc;
    bus.o_instr  = empty ? 32'h0 : head.instr;
    bus.o_except = empty ? EXC_NONE : head.except;
  end
  always_ff @(posedge i_clk) begin
    if (i_ld_we) ram[i_ld_addr] <= i_ld_data;
    if (rd_en) rdata_q <= ram[fpc_q[2+:AW]];
  end
  always_ff @(posedge i_clk) begin
    ipc_q  <= ipc_d;
    iexc_q <= iexc_d;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end
endmodule
